axi_mm_read_mo: RTL and testbench

//  Parametrised AXI4 read master: next generation of the accelerator read DMA. Splits one core request

---
 rtl/axi_mm_read_mo_pkg.sv | 19 +
 rtl/axi_mm_read_mo_burst_sizer.sv | 41 ++++
 rtl/axi_mm_read_mo.sv | 173 +++++++++++++++++
 tb/tb_axi_mm_read_mo.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mm_read_mo_pkg.sv
// Shared constants and FSM encoding for the AXI4 multi-outstanding read master.
package axi_mm_read_mo_pkg;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam int unsigned AXI_4KB_BYTES  = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int unsigned size_log2(input int unsigned dwidth);
        return $clog2(dwidth / 8);
    endfunction

endpackage

// File: rtl/axi_mm_read_mo_burst_sizer.sv
// Registered burst length: min(beats left, MAX_BURST_LEN, beats to the next 4 KB page).
module axi_mm_read_mo_burst_sizer
    import axi_mm_read_mo_pkg::*;
#(
    parameter int unsigned SIZE_LOG2     = 2,
    parameter int unsigned MAX_BURST_LEN = 256
)(
    input  logic        clk,
    input  logic        resetn,
    input  logic [11:0] page_offset,
    input  logic [31:0] beats_left,
    output logic [8:0]  len_b
);

    localparam logic [12:0] PAGE_BYTES = 13'(AXI_4KB_BYTES);

    logic [12:0] page_room;
    logic [12:0] page_beats;
    logic [8:0]  len_d;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        page_room  = PAGE_BYTES - {1'b0, page_offset};
        page_beats = page_room >> SIZE_LOG2;
        len_d      = (beats_left > 32'(MAX_BURST_LEN)) ? 9'(MAX_BURST_LEN) : beats_left[8:0];
        // The page limit is applied last so it always wins over the burst cap.
        if (page_beats < {4'b0, len_d}) begin
            len_d = page_beats[8:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            len_b <= '0;
        end else begin
            len_b <= len_d;
        end
    end

endmodule

// File: rtl/axi_mm_read_mo.sv
// AXI4 read master: splits a core request into INCR bursts, keeps several ARs in flight,
// and streams R beats straight through to the core with a sticky error flag.
module axi_mm_read_mo
    import axi_mm_read_mo_pkg::*;
#(
    parameter int unsigned AXI_AWIDTH      = 32,
    parameter int unsigned AXI_DWIDTH      = 32,
    parameter int unsigned MAX_BURST_LEN   = 256,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [3:0]  AXI_ID          = 4'd0
)(
    input  logic                  clk,
    input  logic                  resetn,
    output logic [3:0]            arid,
    output logic [AXI_AWIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    input  logic [3:0]            rid,
    input  logic [AXI_DWIDTH-1:0] rdata,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic                  rlast,
    input  logic [1:0]            rresp,
    input  logic                  core_read_request_valid,
    output logic                  core_read_request_ready,
    input  logic [AXI_AWIDTH-1:0] core_read_addr,
    input  logic [31:0]           core_read_len,
    output logic [AXI_DWIDTH-1:0] core_read_data,
    output logic                  core_read_data_valid,
    input  logic                  core_read_data_ready,
    output logic                  core_read_done,
    output logic                  core_read_error
);

    localparam int unsigned SIZE_LOG2 = size_log2(AXI_DWIDTH);
    localparam int unsigned OW        = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0]         OUT_MAX  = OW'(MAX_OUTSTANDING);
    localparam logic [AXI_AWIDTH-1:0] LSB_MASK = AXI_AWIDTH'((1 << SIZE_LOG2) - 1);

    state_t                state_q, state_d;
    logic [AXI_AWIDTH-1:0] addr_q, addr_d;
    logic [31:0]           beats_left_q, beats_left_d;
    logic [OW-1:0]         outstanding_q, outstanding_d;
    logic                  arvalid_q, arvalid_d;
    logic                  error_q, error_d;
    logic [8:0]            len_b;

    logic req_fire, ar_fire, r_fire, r_last_fire;

    // Single ID, in-order responses: rid carries no information.
    logic unused_rid;
    assign unused_rid = ^rid;

    assign req_fire    = core_read_request_valid & core_read_request_ready;
    assign ar_fire     = arvalid_q & arready;
    assign r_fire      = rvalid & rready;
    assign r_last_fire = r_fire & rlast;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    state_d = (core_read_len == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: if (beats_left_q == '0) state_d = ST_DRAIN;
            ST_DRAIN: if (outstanding_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM outputs ----------------
    always_comb begin
        core_read_request_ready = (state_q == ST_IDLE);
        rready                  = core_read_data_ready &
                                  ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
        core_read_data_valid    = rvalid & (state_q != ST_IDLE);
        core_read_done          = (state_q == ST_DONE);
        core_read_error         = (state_q == ST_DONE) & error_q;
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        addr_d        = addr_q;
        beats_left_d  = beats_left_q;
        arvalid_d     = arvalid_q;
        outstanding_d = outstanding_q;
        error_d       = error_q;

        if (req_fire) begin
            addr_d       = core_read_addr & ~LSB_MASK;
            beats_left_d = core_read_len;
        end else if (ar_fire) begin
            addr_d       = addr_q + (AXI_AWIDTH'(len_b) << SIZE_LOG2);
            beats_left_d = beats_left_q - 32'(len_b);
        end

        // arvalid stays low for one cycle after each handshake while the sizer settles.
        if (req_fire) begin
            arvalid_d = (core_read_len != '0);
        end else if (ar_fire) begin
            arvalid_d = 1'b0;
        end else if ((state_q == ST_ISSUE) && !arvalid_q &&
                     (beats_left_q != '0) && (outstanding_q < OUT_MAX)) begin
            arvalid_d = 1'b1;
        end

        unique case ({ar_fire, r_last_fire})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase

        if (req_fire) begin
            error_d = 1'b0;
        end else if (r_fire && (rresp != AXI_RESP_OKAY)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_q        <= '0;
            beats_left_q  <= '0;
            arvalid_q     <= 1'b0;
            outstanding_q <= '0;
            error_q       <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            beats_left_q  <= beats_left_d;
            arvalid_q     <= arvalid_d;
            outstanding_q <= outstanding_d;
            error_q       <= error_d;
        end
    end

    // Sizer sees the values the address/count registers are about to take, so len_b
    // is always consistent with addr_q/beats_left_q.
    axi_mm_read_mo_burst_sizer #(
        .SIZE_LOG2     (SIZE_LOG2),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_sizer (
        .clk         (clk),
        .resetn      (resetn),
        .page_offset (addr_d[11:0]),
        .beats_left  (beats_left_d),
        .len_b       (len_b)
    );

    assign arid           = AXI_ID;
    assign araddr         = addr_q;
    assign arvalid        = arvalid_q;
    assign arlen          = 8'(len_b - 9'd1);
    assign arsize         = 3'(SIZE_LOG2);
    assign arburst        = AXI_BURST_INCR;
    assign core_read_data = rdata;

endmodule

// File: tb/tb_axi_mm_read_mo.sv
// Scoreboard bench for axi_mm_read_mo: a small AXI slave model answers ARs, a monitor checks
// every AR, R beat and done pulse against expectations queued when each request is issued.
module tb_axi_mm_read_mo;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MBL = 256;
    localparam int MO  = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [3:0]    arid;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [3:0]    rid;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready;
    logic          rlast;
    logic [1:0]    rresp;
    logic          core_read_request_valid;
    logic          core_read_request_ready;
    logic [AW-1:0] core_read_addr;
    logic [31:0]   core_read_len;
    logic [DW-1:0] core_read_data;
    logic          core_read_data_valid;
    logic          core_read_data_ready;
    logic          core_read_done;
    logic          core_read_error;

    always #5 clk = ~clk;

    axi_mm_read_mo #(
        .AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .MAX_BURST_LEN(MBL), .MAX_OUTSTANDING(MO), .AXI_ID(4'd0)
    ) dut (
        .clk(clk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp),
        .core_read_request_valid(core_read_request_valid),
        .core_read_request_ready(core_read_request_ready),
        .core_read_addr(core_read_addr), .core_read_len(core_read_len),
        .core_read_data(core_read_data), .core_read_data_valid(core_read_data_valid),
        .core_read_data_ready(core_read_data_ready),
        .core_read_done(core_read_done), .core_read_error(core_read_error)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [31:0] addr; int len; int ready_cyc; } burst_t;

    ar_t         exp_ar[$];
    logic [31:0] exp_data[$];
    logic        exp_err[$];
    burst_t      slv_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int r_delay = 0;
    int err_beat = -1;
    int req_beat = 0;
    bit ar_toggle = 0;
    bit dr_toggle = 0;
    bit r_fired = 0;
    bit rlast_seen = 0;
    int ar_before_rlast = 0;
    int ar_total = 0;
    int out_m = 0;
    int max_out = 0;
    int done_count = 0;
    int done_target = 0;
    int arvalid_cycles = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] actual);
        checks++;
        failures++;
        $display("FAIL %s: got 0x%0h with nothing expected (t=%0t)", name, actual, $time);
    endtask

    function automatic logic [31:0] beat_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5AC3_0000;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- stimulus side: AR ready and core backpressure ----------------
    initial begin
        arready = 1'b1;
        core_read_data_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            arready = ar_toggle ? ((cyc % 3) != 0) : 1'b1;
            core_read_data_ready = dr_toggle ? ~core_read_data_ready : 1'b1;
        end
    end

    // ---------------- AXI R slave model ----------------
    initial begin
        bit     have;
        burst_t b;
        int     b_idx;
        have = 0; b_idx = 0;
        rvalid = 0; rlast = 0; rresp = 2'b00; rdata = '0; rid = 4'd0;
        forever begin
            @(posedge clk); #1;
            if (!resetn) begin
                slv_q.delete();
                have = 0;
                rvalid = 0; rlast = 0; rresp = 2'b00;
            end else begin
                if (r_fired) begin
                    b_idx++;
                    req_beat++;
                    if (b_idx > b.len) have = 0;
                end
                if (!have && slv_q.size() > 0 && slv_q[0].ready_cyc <= cyc) begin
                    b = slv_q.pop_front();
                    have = 1;
                    b_idx = 0;
                end
                if (have) begin
                    rvalid = 1'b1;
                    rdata  = beat_data(b.addr + 32'(b_idx * 4));
                    rlast  = (b_idx == b.len);
                    rresp  = (req_beat == err_beat) ? 2'b10 : 2'b00;
                end else begin
                    rvalid = 0; rlast = 0; rresp = 2'b00;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit          prev_stall;
        bit          prev_done;
        logic [31:0] prev_addr;
        logic [7:0]  prev_len;
        ar_t         e;
        logic [31:0] d;
        logic        x;
        prev_stall = 0; prev_done = 0; prev_addr = '0; prev_len = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_stall = 0; prev_done = 0; r_fired = 0;
            end else begin
                if (prev_stall)
                    check("ar_hold", {arvalid, araddr, arlen}, {1'b1, prev_addr, prev_len});
                if (arvalid) arvalid_cycles++;
                if (arvalid && arready) begin
                    if (exp_ar.size() == 0) begin
                        fail_now("ar_unexpected", araddr);
                    end else begin
                        e = exp_ar.pop_front();
                        check("araddr", araddr, e.addr);
                        check("arlen", arlen, e.len);
                        check("ar_consts", {arid, arsize, arburst}, {4'd0, 3'd2, 2'b01});
                    end
                    slv_q.push_back('{araddr, int'(arlen), cyc + r_delay});
                    ar_total++;
                    if (!rlast_seen) ar_before_rlast++;
                    out_m++;
                    if (out_m > max_out) max_out = out_m;
                    check("outstanding_cap", out_m <= MO, 1);
                end
                prev_stall = arvalid && !arready;
                prev_addr  = araddr;
                prev_len   = arlen;

                r_fired = rvalid && rready;
                if (r_fired) begin
                    if (exp_data.size() == 0) begin
                        fail_now("beat_unexpected", core_read_data);
                    end else begin
                        d = exp_data.pop_front();
                        check("rdata", core_read_data, d);
                        check("data_valid", core_read_data_valid, 1'b1);
                    end
                    if (rlast) begin
                        out_m--;
                        rlast_seen = 1;
                    end
                end

                if (core_read_done) begin
                    check("done_single_cycle", prev_done, 1'b0);
                    if (exp_err.size() == 0) begin
                        fail_now("done_unexpected", core_read_error);
                    end else begin
                        x = exp_err.pop_front();
                        check("done_error", core_read_error, x);
                    end
                    done_count++;
                end else begin
                    check("error_without_done", core_read_error, 1'b0);
                end
                prev_done = core_read_done;
            end
        end
    end

    // ---------------- request helpers ----------------
    task automatic expect_ar(input logic [31:0] a, input logic [7:0] l);
        exp_ar.push_back('{a, l});
    endtask

    task automatic issue(input logic [31:0] addr, input int len, input int err_idx);
        int n;
        for (int i = 0; i < len; i++) exp_data.push_back(beat_data(addr + 32'(i * 4)));
        exp_err.push_back(err_idx >= 0 && err_idx < len);
        done_target++;
        err_beat = err_idx;
        req_beat = 0;
        rlast_seen = 0;
        ar_before_rlast = 0;
        max_out = 0;
        @(posedge clk); #1;
        core_read_request_valid = 1'b1;
        core_read_addr = addr;
        core_read_len = 32'(len);
        n = 0;
        while (!core_read_request_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) fail_now("request_ready_timeout", n);
        @(posedge clk); #1;
        core_read_request_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_count < done_target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", done_count >= done_target, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int saved;
        core_read_request_valid = 1'b0;
        core_read_addr = '0;
        core_read_len = '0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {arvalid, rready, core_read_done, core_read_error}, 4'b0000);
        check("reset_request_ready", core_read_request_ready, 1'b1);
        @(posedge clk); #1;
        resetn = 1'b1;

        // single burst
        expect_ar(32'h1000, 8'd7);
        issue(32'h1000, 8, -1);
        wait_done(200);
        check("t1_ar_count", ar_total, 1);

        // three bursts capped at 256 beats, AR ready toggling
        ar_toggle = 1;
        expect_ar(32'h0000, 8'd255);
        expect_ar(32'h0400, 8'd255);
        expect_ar(32'h0800, 8'd87);
        issue(32'h0000, 600, -1);
        wait_done(3000);
        check("t2_ars_before_rlast", ar_before_rlast, 3);
        ar_toggle = 0;

        // 4 KB split: 4 beats to the page edge, then the rest
        expect_ar(32'h0FF0, 8'd3);
        expect_ar(32'h1000, 8'd5);
        issue(32'h0FF0, 10, -1);
        wait_done(200);

        // outstanding limit with slow R channel
        r_delay = 50;
        for (int i = 0; i < 8; i++) expect_ar(32'(i * 32'h400), 8'd255);
        issue(32'h0000, 2048, -1);
        wait_done(6000);
        check("t4_ars_before_rlast", ar_before_rlast, MO);
        check("t4_max_outstanding", max_out, MO);
        r_delay = 0;

        // error on beat index 3 with toggling core backpressure, then a clean request
        dr_toggle = 1;
        expect_ar(32'h2000, 8'd7);
        issue(32'h2000, 8, 3);
        wait_done(300);
        dr_toggle = 0;
        expect_ar(32'h3000, 8'd3);
        issue(32'h3000, 4, -1);
        wait_done(200);

        // zero-length request: done one cycle after fire, no AR traffic
        saved = arvalid_cycles;
        issue(32'h4000, 0, -1);
        @(negedge clk);
        check("len0_done", core_read_done, 1'b1);
        @(negedge clk);
        check("len0_done_drop", {core_read_done, core_read_request_ready}, 2'b01);
        check("len0_no_arvalid", arvalid_cycles, saved);

        // reset in the middle of DRAIN
        r_delay = 20;
        saved = ar_total;
        expect_ar(32'h5000, 8'd7);
        issue(32'h5000, 8, -1);
        for (int n = 0; n < 50 && ar_total == saved; n++) @(negedge clk);
        check("drain_ar_seen", ar_total, saved + 1);
        repeat (3) @(negedge clk);
        check("drain_rready", rready, 1'b1);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        check("midreset_outputs", {arvalid, rready, core_read_done}, 3'b000);
        exp_ar.delete();
        exp_data.delete();
        exp_err.delete();
        done_target--;
        out_m = 0;
        r_delay = 0;
        @(posedge clk); #1;
        resetn = 1'b1;
        expect_ar(32'h6000, 8'd1);
        issue(32'h6000, 2, -1);
        wait_done(200);

        repeat (5) @(negedge clk);
        check("leftover_beats", exp_data.size(), 0);
        check("leftover_ars", exp_ar.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
